// File: rtl/video_frame_checker.sv
// video_frame_checker: AXI4-Stream video sink that checks SOF/EOL framing and line/frame geometry,
// counts good frames, error events and dropped beats, and reports a per-frame additive pixel checksum.
module video_frame_checker #(
  parameter int DATAW    = 32,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             stall,
  input  logic             clr_err,
  input  logic [DATAW-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic [31:0]      frame_sum,
  output logic [2:0]       err_flags,
  output logic [15:0]      err_cnt,
  output logic [15:0]      drop_cnt
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_SOF = 2'd1;
  localparam logic [1:0] ACTIVE   = 2'd2;
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE + 1);
  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d, cx;
  logic [YW-1:0] y_q, y_d, cy;
  logic [31:0]   sum_q, sum_d, nsum, frame_sum_q, frame_sum_d;
  logic          tready_q, frame_done_q, frame_done_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [2:0]    err_flags_q, err_flags_d;
  logic [16:0]   errs;
  logic          acc, proc, restart, last_col, last_row, e0, e1, e2, good, drop;
  logic          unused_tdata;
  assign unused_tdata = ^s_axis_tdata;
  always_comb begin
    acc      = s_axis_tvalid & tready_q & en;
    proc     = acc & ((state_q == ACTIVE) | ((state_q == WAIT_SOF) & s_axis_tuser));
    e0       = acc & (state_q == ACTIVE) & s_axis_tuser & ((x_q != '0) | (y_q != '0));
    // a fresh SOF (from WAIT_SOF or a mid-frame restart) is always pixel (0,0) with an empty sum
    restart  = (state_q == WAIT_SOF) | e0;
    cx       = restart ? '0 : x_q;
    cy       = restart ? '0 : y_q;
    nsum     = (restart ? 32'd0 : sum_q) + {8'd0, s_axis_tdata[23:0]};
    last_col = cx == XW'(H_ACTIVE - 1);
    last_row = cy == YW'(V_ACTIVE - 1);
    e1       = proc & s_axis_tlast & ~last_col;
    e2       = proc & ~s_axis_tlast & last_col;
    good     = proc & s_axis_tlast & last_col & last_row;
    drop     = acc & (state_q == WAIT_SOF) & ~s_axis_tuser;
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    sum_d    = sum_q;
    if (!en) begin
      state_d = IDLE;
      x_d     = '0;
      y_d     = '0;
      sum_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = WAIT_SOF;
    end else if (proc) begin
      state_d = (e1 | e2 | good) ? WAIT_SOF : ACTIVE;
      x_d     = (e1 | e2 | good | s_axis_tlast) ? '0 : cx + 1'b1;
      y_d     = (e1 | e2 | good) ? '0 : (s_axis_tlast ? cy + 1'b1 : cy);
      sum_d   = (e1 | e2 | good) ? '0 : nsum;
    end
    errs         = {1'b0, err_cnt_q} + 17'(e0) + 17'(e1) + 17'(e2);
    err_cnt_d    = clr_err ? '0 : (errs[16] ? 16'hFFFF : errs[15:0]);
    err_flags_d  = clr_err ? '0 : (err_flags_q | {e2, e1, e0});
    drop_cnt_d   = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    frame_cnt_d  = frame_cnt_q + 16'(good);
    frame_sum_d  = good ? nsum : frame_sum_q;
    frame_done_d = good;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      sum_q        <= '0;
      tready_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      frame_sum_q  <= '0;
      err_flags_q  <= '0;
      err_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sum_q        <= sum_d;
      tready_q     <= en & ~stall;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_sum_q  <= frame_sum_d;
      err_flags_q  <= err_flags_d;
      err_cnt_q    <= err_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end
  assign s_axis_tready = tready_q;
  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;
  assign frame_sum     = frame_sum_q;
  assign err_flags     = err_flags_q;
  assign err_cnt       = err_cnt_q;
  assign drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_video_frame_checker.sv
// tb_video_frame_checker: random-stimulus bench comparing video_frame_checker against a pixel-index reference model.
module tb_video_frame_checker;
  localparam int H = 8;
  localparam int V = 4;
  logic        clk = 1'b0;
  logic        rst, en, stall, clr_err, tvalid, tuser, tlast, tready, frame_done;
  logic [31:0] tdata, frame_sum;
  logic [15:0] frame_cnt, err_cnt, drop_cnt;
  logic [2:0]  err_flags;
  int          n_chk = 0, n_err = 0, done_seen = 0;
  bit          m_rdy, m_in, m_done;
  int          m_pos;
  logic [31:0] m_sum, m_fsum;
  logic [15:0] m_fcnt, m_ecnt, m_drop;
  logic [2:0]  m_flags;

  always #5 clk = ~clk;

  video_frame_checker #(.DATAW(32), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .clr_err(clr_err),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tuser(tuser), .s_axis_tlast(tlast), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .frame_sum(frame_sum), .err_flags(err_flags),
    .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a frame is a linear run of H*V pixels; x/y are derived from the pixel index.
  task automatic model_step();
    bit   acc;
    bit   [2:0] e;
    int   x, y, tot;
    acc    = tvalid & m_rdy & en;
    e      = '0;
    m_done = 0;
    if (rst) begin
      m_in = 0; m_pos = 0; m_sum = 0; m_fsum = 0; m_fcnt = 0; m_ecnt = 0; m_drop = 0; m_flags = 0;
    end else begin
      if (!en) begin
        m_in = 0; m_pos = 0; m_sum = 0;
      end else if (acc) begin
        if (!m_in && !tuser) begin
          if (m_drop != 16'hFFFF) m_drop++;
        end else begin
          if (!m_in) begin
            m_in = 1; m_pos = 0; m_sum = 0;
          end else if (tuser && m_pos != 0) begin
            e[0] = 1; m_pos = 0; m_sum = 0;
          end
          x = m_pos % H;
          y = m_pos / H;
          m_sum += {8'd0, tdata[23:0]};
          if (tlast && x != H - 1) begin
            e[1] = 1; m_in = 0;
          end else if (!tlast && x == H - 1) begin
            e[2] = 1; m_in = 0;
          end else if (m_pos == H * V - 1) begin
            m_done = 1; m_fcnt++; m_fsum = m_sum; m_in = 0;
          end else m_pos++;
        end
      end
      if (clr_err) begin
        m_flags = 0; m_ecnt = 0;
      end else begin
        m_flags |= e;
        tot = int'(m_ecnt) + int'(e[0]) + int'(e[1]) + int'(e[2]);
        m_ecnt = (tot > 65535) ? 16'hFFFF : 16'(tot);
      end
    end
    m_rdy = !rst && en && !stall;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (frame_done) done_seen++;
    chk("tready", 32'(tready), 32'(m_rdy));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    chk("frame_sum", frame_sum, m_fsum);
    chk("err_flags", 32'(err_flags), 32'(m_flags));
    chk("err_cnt", 32'(err_cnt), 32'(m_ecnt));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic send(input logic [31:0] d, input bit u, input bit l, input bit rs);
    bit a;
    int n = 0;
    tvalid = 1; tdata = d; tuser = u; tlast = l;
    do begin
      if (rs) stall = ($urandom_range(0, 9) < 3);
      a = m_rdy & en;
      cyc();
      n++;
    end while (!a && n < 200);
    chk("accept", 32'(a), 32'd1);
  endtask

  function automatic logic [31:0] pix(input int pat, input int x, input int y);
    return pat == 0 ? 32'd1 :
           pat == 1 ? (y < V / 2 ? 32'h0000FF : (x < H / 2 ? 32'h00FF00 : 32'hFF0000)) :
           $urandom;
  endfunction

  task automatic send_frame(input int pat, input bit rs);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        send(pix(pat, x, y), x == 0 && y == 0, x == H - 1, rs);
  endtask

  task automatic idle(input int n);
    tvalid = 0; tuser = 0; tlast = 0; stall = 0;
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    rst = 1; en = 0; stall = 0; clr_err = 0; tvalid = 0; tuser = 0; tlast = 0; tdata = 0;
    m_rdy = 0;
    repeat (2) cyc();
    rst = 0; en = 1;
    cyc();
    done_seen = 0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_frame_sum", frame_sum, 32'd0);
    chk("rst_err_flags", 32'(err_flags), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    send_frame(0, 0);
    send_frame(0, 0);
    idle(2);
    chk("bb_done_pulses", 32'(done_seen), 32'd2);
    chk("bb_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("bb_frame_sum", frame_sum, 32'd32);
    chk("bb_err_flags", 32'(err_flags), 32'd0);
    chk("bb_drop_cnt", 32'(drop_cnt), 32'd0);

    do_reset();
    send_frame(1, 0);
    idle(2);
    chk("tpg_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("tpg_frame_sum", frame_sum, 32'h080007F0);
    chk("tpg_err_flags", 32'(err_flags), 32'd0);

    do_reset();
    for (int i = 0; i < 3; i++) send($urandom, 0, 0, 0);
    send_frame(2, 0);
    idle(2);
    chk("drop_drop_cnt", 32'(drop_cnt), 32'd3);
    chk("drop_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("drop_err_cnt", 32'(err_cnt), 32'd0);

    do_reset();
    for (int x = 0; x < H; x++) send(1, x == 0, x == H - 1, 0);
    for (int x = 0; x <= 5; x++) send(1, 0, x == 5, 0);
    idle(2);
    chk("eol_err_flags", 32'(err_flags), 32'd2);
    chk("eol_err_cnt", 32'(err_cnt), 32'd1);
    chk("eol_no_done", 32'(done_seen), 32'd0);
    send(1, 0, 0, 0);
    idle(1);
    chk("eol_drop_cnt", 32'(drop_cnt), 32'd1);
    send_frame(2, 0);
    idle(2);
    chk("eol_frame_cnt", 32'(frame_cnt), 32'd1);

    do_reset();
    for (int i = 0; i < 2 * H + 3; i++) send(2, i == 0, i % H == H - 1, 0);
    send_frame(0, 0);
    idle(2);
    chk("sof_err_flags", 32'(err_flags), 32'd1);
    chk("sof_done", 32'(done_seen), 32'd1);
    chk("sof_frame_sum", frame_sum, 32'd32);

    do_reset();
    for (int x = 0; x < H - 1; x++) send(3, x == 0, 0, 0);
    send(3, 0, 0, 0);
    idle(2);
    chk("miss_err_flags", 32'(err_flags), 32'd4);
    chk("miss_err_cnt", 32'(err_cnt), 32'd1);

    for (int i = 0; i < 2 * H + 3; i++) send(4, i == 0, i % H == H - 1, 0);
    send(4, 1, 1, 0);
    idle(1);
    chk("dual_err_flags", 32'(err_flags), 32'd7);
    chk("dual_err_cnt", 32'(err_cnt), 32'd3);
    clr_err = 1;
    idle(1);
    clr_err = 0;
    chk("clr_err_flags", 32'(err_flags), 32'd0);
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);

    do_reset();
    for (int i = 0; i < H + 2; i++) send($urandom, i == 0, i % H == H - 1, 1);
    tvalid = 1; tuser = 0; tlast = 0;
    en = 0;
    repeat (3) begin
      stall = ($urandom_range(0, 9) < 3);
      cyc();
    end
    en = 1;
    idle(2);
    send_frame(2, 1);
    idle(3);
    chk("stall_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("stall_done", 32'(done_seen), 32'd1);
    chk("stall_frame_sum", frame_sum, m_fsum);
    chk("stall_err_cnt", 32'(err_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/video_frame_checker.md
Name: video_frame_checker

Overview:
AXI4-Stream video sink that consumes a 24-bit-per-pixel raster and checks its framing.
- Checks SOF on tuser, EOL on tlast, and line/frame geometry.
- Counts good frames and errors, and produces a per-frame additive checksum of pixel data.
- Sits downstream of the test-pattern generator, or of any video pipeline stage, as a bring-up and regression monitor. Drives tready, with optional backpressure for stress testing.

Parameters:
DATAW, 32, stream data width; only tdata[23:0] is used for the checksum.
H_ACTIVE, 1280, pixels per line; must be >= 2.
V_ACTIVE, 720, lines per frame; must be >= 1.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  checker enable; 0 forces IDLE
stall  in  1  backpressure request; 1 deasserts tready
clr_err  in  1  clears sticky error flags and err_cnt
s_axis_tdata  in  DATAW  pixel data
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  beat ready
s_axis_tuser  in  1  start of frame
s_axis_tlast  in  1  end of line
frame_done  out  1  1-cycle pulse on completion of a good frame
frame_cnt  out  16  good-frame count, wraps
frame_sum  out  32  checksum of last good frame
err_flags  out  3  sticky flags: [0] unexpected SOF, [1] early EOL, [2] late/missing EOL
err_cnt  out  16  total error events, saturates at 0xFFFF
drop_cnt  out  16  beats discarded in WAIT_SOF, saturates at 0xFFFF

Behaviour:
- Reset values: s_axis_tready=0, frame_done=0, frame_cnt=0, frame_sum=0, err_flags=0, err_cnt=0, drop_cnt=0, state=IDLE, x=0, y=0, running sum=0.
- tready is registered: s_axis_tready <= en & ~stall, giving 1-cycle latency. A beat is accepted when tvalid & tready.
- en=0 at a clock edge:
  - state -> IDLE, and x, y and running sum are cleared.
  - Any concurrent beat is ignored.
  - frame_cnt, frame_sum, err_* and drop_cnt are held.
- IDLE -> WAIT_SOF when en=1.
- WAIT_SOF, accepted beat:
  - tuser=0: beat dropped, drop_cnt++.
  - tuser=1: state -> ACTIVE. The beat is pixel (0,0) and is processed by the ACTIVE rules below.
- ACTIVE, accepted beat, evaluated in this order:
  1. tuser=1 and (x,y)!=(0,0): err_flags[0] set, err_cnt++. Restart the frame at this beat: x=0, y=0, sum=0.
  2. sum += zero-extended tdata[23:0], mod 2^32.
  3. tlast=1 and x!=H_ACTIVE-1: err_flags[1] set, err_cnt++, state -> WAIT_SOF, sum discarded.
  4. tlast=0 and x==H_ACTIVE-1: err_flags[2] set, err_cnt++, state -> WAIT_SOF.
  5. tlast=1 and x==H_ACTIVE-1:
     - Set x=0.
     - If y==V_ACTIVE-1: frame_done=1 next cycle, frame_cnt++, frame_sum <= final sum including this beat, y=0, state -> WAIT_SOF.
     - Otherwise y++.
  6. Otherwise x++.
- After a good frame, the next frame must begin with tuser=1. Beats without tuser are dropped and counted in drop_cnt, not flagged as errors.
- Simultaneous error events in one beat increment err_cnt once per event type (max +2/cycle), saturating.
- clr_err=1 clears err_flags and err_cnt; a same-cycle error event is lost (clear wins). drop_cnt is cleared by rst only.
- No combinational path from any s_axis input to any output.

Test Plan:
- H=8, V=4, tdata=1, tuser on first beat, tlast every 8th beat, two back-to-back frames, stall=0 -> frame_done pulses twice, frame_cnt=2, frame_sum=32, err_flags=0, drop_cnt=0.
- Default params, frame from the test-pattern generator (top half 0x0000FF; bottom-left 0x00FF00; bottom-right 0xFF0000) -> frame_sum=0x037CF800, frame_cnt=1, err_flags=0.
- H=8, V=4, three beats without tuser, then a good frame -> drop_cnt=3, frame_cnt=1, err_cnt=0.
- H=8, V=4, tlast at x=5 on line 1 -> err_flags=3'b010, err_cnt=1, no frame_done. Next beat without tuser -> drop_cnt=1. Then tuser frame completes -> frame_cnt=1.
- H=8, V=4, tuser reasserted at (3,2) then full frame -> err_flags=3'b001, frame_done on completion of the restarted frame. A separate run with a missing tlast at x=7 -> err_flags[2]=1.
- Random stall (~30%) with tvalid held on stall cycles, plus en dropped mid-frame then re-raised before a fresh frame -> first frame uncounted, second frame good with correct sum, tready follows en&~stall with 1 cycle latency, frame_cnt=1.
